// File: rtl/spi_pkg.sv
// ============================================================================
// Package  : spi_pkg - shared types and constants for the SPI bus arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package spi_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DONE  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_HOLD  = 3'd5
  } arb_state_t;

  localparam logic PORT_LCD = 1'b0;
  localparam logic PORT_RTP = 1'b1;

  // Mode 0: clock idles low, data sampled on the rising edge
  localparam logic [1:0] SPI_MODE = 2'd0;
  localparam logic       SPI_CPOL = SPI_MODE[1];

endpackage

`default_nettype wire

// File: rtl/spi_bus_arbiter_if.sv
// ============================================================================
// Interface: spi_bus_arbiter_if - requester handshakes and board SPI pins
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface spi_bus_arbiter_if;
  logic       REQ0;
  logic [7:0] DATA0;
  logic       DCX0;
  logic       LAST0;
  logic       DONE0;
  logic [7:0] RX0;
  logic       REQ1;
  logic [7:0] DATA1;
  logic       LAST1;
  logic       DONE1;
  logic [7:0] RX1;
  logic       BUSY;
  logic       SCK;
  logic       SDO;
  logic       SDI;
  logic       LCD_CSX;
  logic       RTP_CSX;
  logic       LCD_DCX;

  modport slave (
    input  REQ0, DATA0, DCX0, LAST0, REQ1, DATA1, LAST1, SDI,
    output DONE0, RX0, DONE1, RX1, BUSY, SCK, SDO, LCD_CSX, RTP_CSX, LCD_DCX
  );

  modport master (
    output REQ0, DATA0, DCX0, LAST0, REQ1, DATA1, LAST1, SDI,
    input  DONE0, RX0, DONE1, RX1, BUSY, SCK, SDO, LCD_CSX, RTP_CSX, LCD_DCX
  );
endinterface

`default_nettype wire

// File: rtl/spi_shift_engine.sv
// ============================================================================
// Module   : spi_shift_engine - one-byte mode-0 SPI shifter with clock divider
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_shift_engine
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] tx_byte,
  input  logic       sdi,
  output logic       sck,
  output logic       sdo,
  output logic [7:0] rx_byte,
  output logic       done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic       r_busy;
  logic [7:0] r_div;
  logic [4:0] r_half;
  logic [7:0] r_sh;
  logic       r_sck;
  logic       r_sdo;
  logic       w_end;

  // Half 0 is the setup phase; halves 1..16 alternate SCK high / low
  assign w_end = r_busy && (r_div == 8'd0) && (r_half == 5'd16);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_busy <= 1'b0;
      r_div  <= 8'd0;
      r_half <= 5'd0;
      r_sh   <= 8'd0;
      r_sck  <= SPI_CPOL;
      r_sdo  <= 1'b0;
    end else if (start) begin
      r_busy <= 1'b1;
      r_div  <= DIV_LAST;
      r_half <= 5'd0;
      r_sh   <= tx_byte;
      r_sck  <= SPI_CPOL;
      r_sdo  <= tx_byte[7];
    end else if (w_end) begin
      r_busy <= 1'b0;
    end else if (r_busy) begin
      if (r_div != 8'd0) begin
        r_div <= r_div - 8'd1;
      end else begin
        r_div  <= DIV_LAST;
        r_half <= r_half + 5'd1;
        if (!r_half[0]) begin
          r_sck <= ~SPI_CPOL;
          r_sh  <= {r_sh[6:0], sdi};
        end else begin
          r_sck <= SPI_CPOL;
          // Bit 0 stays on SDO through the final low phase
          if (r_half != 5'd15) begin
            r_sdo <= r_sh[7];
          end
        end
      end
    end
  end

  assign sck     = r_sck;
  assign sdo     = r_sdo;
  assign rx_byte = r_sh;
  assign done    = w_end;

endmodule

`default_nettype wire

// File: rtl/spi_bus_arbiter.sv
// ============================================================================
// Module   : spi_bus_arbiter - locks one SPI shifter to the LCD or touch port
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_bus_arbiter
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned CS_HOLD = 2
) (
  input  logic              CLK,
  input  logic              RST,
  spi_bus_arbiter_if.slave  bus
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_owner;
  logic       r_rr_last;
  logic       r_last;
  logic [7:0] r_cnt;
  logic       r_lcd_dcx;
  logic [7:0] r_rx0;
  logic [7:0] r_rx1;

  logic       w_start;
  logic       w_port;
  logic       w_owner_req;
  logic [7:0] w_sel_data;
  logic       w_sel_last;
  logic       w_cs_active;
  logic       w_sck;
  logic       w_sdo;
  logic [7:0] w_rx;
  logic       w_eng_done;

  assign w_owner_req = (r_owner == PORT_RTP) ? bus.REQ1 : bus.REQ0;
  assign w_sel_data  = (w_port == PORT_RTP) ? bus.DATA1 : bus.DATA0;
  assign w_sel_last  = (w_port == PORT_RTP) ? bus.LAST1 : bus.LAST0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_port  = r_owner;
    case (r_state)
      ST_IDLE: begin
        if (bus.REQ0 || bus.REQ1) begin
          w_start = 1'b1;
          w_next  = ST_SETUP;
          if (bus.REQ0 && bus.REQ1) begin
            w_port = ~r_rr_last;
          end else begin
            w_port = bus.REQ1 ? PORT_RTP : PORT_LCD;
          end
        end
      end
      ST_SETUP: if (r_cnt == 8'd0) w_next = ST_SHIFT;
      ST_SHIFT: if (w_eng_done) w_next = ST_DONE;
      ST_DONE:  w_next = r_last ? ST_HOLD : ST_WAIT;
      // Locked: the other port cannot break in between bytes
      ST_WAIT: begin
        if (w_owner_req) begin
          w_start = 1'b1;
          w_next  = ST_SETUP;
        end
      end
      ST_HOLD:  if (r_cnt == 8'd0) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_owner   <= PORT_LCD;
      r_rr_last <= PORT_RTP;
      r_last    <= 1'b0;
      r_cnt     <= 8'd0;
      r_lcd_dcx <= 1'b0;
      r_rx0     <= 8'd0;
      r_rx1     <= 8'd0;
    end else begin
      if (w_start) begin
        r_owner <= w_port;
        r_last  <= w_sel_last;
        r_cnt   <= 8'(CLK_DIV - 1);
        if (w_port == PORT_LCD) begin
          r_lcd_dcx <= bus.DCX0;
        end
      end else if (r_state == ST_DONE && r_last) begin
        r_rr_last <= r_owner;
        r_cnt     <= 8'(CS_HOLD - 1);
      end else if ((r_state == ST_SETUP || r_state == ST_HOLD) && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (r_state == ST_SHIFT && w_eng_done) begin
        if (r_owner == PORT_RTP) begin
          r_rx1 <= w_rx;
        end else begin
          r_rx0 <= w_rx;
        end
      end
    end
  end

  always_comb begin
    w_cs_active = (r_state == ST_SETUP) || (r_state == ST_SHIFT) ||
                  (r_state == ST_DONE)  || (r_state == ST_WAIT);
    bus.LCD_CSX = ~(w_cs_active && (r_owner == PORT_LCD));
    bus.RTP_CSX = ~(w_cs_active && (r_owner == PORT_RTP));
    bus.BUSY    = (r_state != ST_IDLE);
    bus.DONE0   = (r_state == ST_DONE) && (r_owner == PORT_LCD);
    bus.DONE1   = (r_state == ST_DONE) && (r_owner == PORT_RTP);
    bus.RX0     = r_rx0;
    bus.RX1     = r_rx1;
    bus.LCD_DCX = r_lcd_dcx;
    bus.SCK     = w_sck;
    bus.SDO     = w_sdo;
  end

  spi_shift_engine #(
    .CLK_DIV (CLK_DIV)
  ) u_engine (
    .CLK     (CLK),
    .RST     (RST),
    .start   (w_start),
    .tx_byte (w_sel_data),
    .sdi     (bus.SDI),
    .sck     (w_sck),
    .sdo     (w_sdo),
    .rx_byte (w_rx),
    .done    (w_eng_done)
  );

endmodule

`default_nettype wire

// File: tb/tb_spi_bus_arbiter.sv
// ============================================================================
// Module   : tb_spi_bus_arbiter - directed self-checking bench for the arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_bus_arbiter;

  localparam int CS_HOLD = 2;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  spi_bus_arbiter_if sif ();
  spi_bus_arbiter_if sif1 ();

  spi_bus_arbiter #(.CLK_DIV(4), .CS_HOLD(CS_HOLD)) dut (
    .CLK (CLK), .RST (RST), .bus (sif)
  );
  spi_bus_arbiter #(.CLK_DIV(1), .CS_HOLD(CS_HOLD)) dut_min (
    .CLK (CLK), .RST (RST), .bus (sif1)
  );

  // SPI slave model: shifts the pattern out MSB first, advancing on SCK falls
  logic [7:0] sdi_pat;
  logic [2:0] bit_idx;
  always @(negedge sif.SCK or posedge RST) begin
    if (RST) bit_idx <= 3'd0;
    else     bit_idx <= bit_idx + 3'd1;
  end
  assign sif.SDI  = sdi_pat[3'd7 - bit_idx];
  assign sif1.SDI = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int p, input bit req, input logic [7:0] d, input bit dcx, input bit last);
    if (p == 0) begin
      sif.REQ0 = req; sif.DATA0 = d; sif.DCX0 = dcx; sif.LAST0 = last;
    end else begin
      sif.REQ1 = req; sif.DATA1 = d; sif.LAST1 = last;
    end
  endtask

  task automatic reset_dut();
    @(negedge CLK); RST = 1'b1;
    @(negedge CLK); RST = 1'b0;
    @(negedge CLK);
  endtask

  // One byte on port p, starting in the current cycle (cycle 0). Returns the
  // cycle of the DONE pulse, SDO bits seen at SCK rises, and a count of
  // chip-select / foreign-DONE violations.
  task automatic xfer(input int p, input logic [7:0] d, input bit dcx, input bit last,
                      output int lat, output logic [7:0] bits, output int err);
    logic prev_sck;
    drive(p, 1'b1, d, dcx, last);
    lat = -1; bits = 8'h00; err = 0; prev_sck = sif.SCK;
    for (int n = 1; n <= 400 && lat < 0; n++) begin
      @(negedge CLK);
      if (sif.SCK === 1'b1 && prev_sck === 1'b0) bits = {bits[6:0], sif.SDO};
      prev_sck = sif.SCK;
      if (((p == 0) ? sif.LCD_CSX : sif.RTP_CSX) !== 1'b0) err++;
      if (((p == 0) ? sif.RTP_CSX : sif.LCD_CSX) !== 1'b1) err++;
      if (((p == 0) ? sif.DONE1 : sif.DONE0) !== 1'b0) err++;
      if (((p == 0) ? sif.DONE0 : sif.DONE1) === 1'b1) lat = n;
    end
    if (p == 0) sif.REQ0 = 1'b0; else sif.REQ1 = 1'b0;
  endtask

  typedef struct {
    int         port;
    logic [7:0] data;
    bit         dcx;
    logic [7:0] pat;
    logic [7:0] exp_rx;
    bit         exp_dcx;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] mb[5];
  logic [7:0] rx_model[2];
  int         lat, err, got0, got1, rtp_first, viol, k_grant, d0, cnt0, cnt1, ndone;
  int         rises, seen, d1, sdo_err, sck_err;
  logic [7:0] bits, order;
  logic       prev;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{0, 8'hA5, 1'b1, 8'h3C, 8'h3C, 1'b1};
    vecs[1] = '{1, 8'h5A, 1'b0, 8'hC3, 8'hC3, 1'b1};
    vecs[2] = '{0, 8'h00, 1'b0, 8'hFF, 8'hFF, 1'b0};
    vecs[3] = '{1, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0};
    vecs[4] = '{0, 8'h81, 1'b1, 8'h7E, 8'h7E, 1'b1};
    mb = '{8'h80, 8'h0A, 8'h19, 8'h08, 8'h16};
    rx_model = '{8'h00, 8'h00};

    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    sif1.REQ0 = 1'b0; sif1.DATA0 = 8'h00; sif1.DCX0 = 1'b0; sif1.LAST0 = 1'b0;
    sif1.REQ1 = 1'b0; sif1.DATA1 = 8'h00; sif1.LAST1 = 1'b0;
    sdi_pat = 8'h00;

    @(negedge CLK); @(negedge CLK);
    check("reset_outputs",
          {sif.SCK, sif.SDO, sif.LCD_CSX, sif.RTP_CSX, sif.LCD_DCX, sif.DONE0, sif.DONE1, sif.BUSY, sif.RX0, sif.RX1},
          {8'b0011_0000, 8'h00, 8'h00});
    RST = 1'b0;
    @(negedge CLK);

    // Single-byte table, alternating ports
    for (int i = 0; i < 5; i++) begin
      sdi_pat = vecs[i].pat;
      xfer(vecs[i].port, vecs[i].data, vecs[i].dcx, 1'b1, lat, bits, err);
      check("vec_latency", lat, 69);
      check("vec_sdo_bits", bits, vecs[i].data);
      check("vec_rx_owner", (vecs[i].port == 1) ? sif.RX1 : sif.RX0, vecs[i].exp_rx);
      check("vec_rx_other", (vecs[i].port == 1) ? sif.RX0 : sif.RX1, rx_model[1 - vecs[i].port]);
      check("vec_lcd_dcx", sif.LCD_DCX, vecs[i].exp_dcx);
      check("vec_cs_lock", err, 0);
      rx_model[vecs[i].port] = vecs[i].exp_rx;
      @(negedge CLK);
      check("vec_hold_state", {sif.BUSY, sif.LCD_CSX, sif.RTP_CSX}, 3'b111);
      @(negedge CLK); @(negedge CLK);
      check("vec_idle_busy", sif.BUSY, 1'b0);
    end

    // Simultaneous requests right after reset: port 0 first
    reset_dut();
    sdi_pat = 8'h55;
    drive(0, 1'b1, 8'h11, 1'b0, 1'b1);
    drive(1, 1'b1, 8'h22, 1'b0, 1'b1);
    got0 = -1; got1 = -1; rtp_first = -1; viol = 0;
    for (int n = 1; n <= 400 && got1 < 0; n++) begin
      @(negedge CLK);
      if (sif.LCD_CSX === 1'b0 && sif.RTP_CSX === 1'b0) viol++;
      if (sif.RTP_CSX === 1'b0 && rtp_first < 0) rtp_first = n;
      if (sif.DONE0 === 1'b1) begin got0 = n; sif.REQ0 = 1'b0; end
      if (sif.DONE1 === 1'b1) begin got1 = n; sif.REQ1 = 1'b0; end
    end
    sif.REQ0 = 1'b0; sif.REQ1 = 1'b0;
    check("sim_done0_cycle", got0, 69);
    check("sim_rtp_select_cycle", rtp_first, 73);
    check("sim_done1_cycle", got1, 141);
    check("sim_no_overlap", viol, 0);
    @(negedge CLK); @(negedge CLK); @(negedge CLK);

    // Locked 5-byte touch transaction with LCD request arriving mid-way
    sdi_pat = 8'h96;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive(0, 1'b1, 8'h5C, 1'b0, 1'b1);
      xfer(1, mb[i], 1'b0, (i == 4), lat, bits, err);
      check("mb_latency", lat, (i == 0) ? 69 : 70);
      check("mb_sdo_bits", bits, mb[i]);
      check("mb_lock", err, 0);
    end
    check("mb_rx1", sif.RX1, 8'h96);
    k_grant = -1;
    for (int k = 1; k <= 20 && k_grant < 0; k++) begin
      @(negedge CLK);
      if (sif.LCD_CSX === 1'b0) k_grant = k;
    end
    check("mb_port0_after_hold", k_grant, CS_HOLD + 2);
    d0 = -1;
    for (int k = 1; k <= 200 && d0 < 0; k++) begin
      @(negedge CLK);
      if (sif.DONE0 === 1'b1) d0 = k;
    end
    sif.REQ0 = 1'b0;
    check("mb_port0_done", d0, 68);
    check("mb_rx0", sif.RX0, 8'h96);

    // Round-robin with both ports requesting back to back
    reset_dut();
    drive(0, 1'b1, 8'h01, 1'b1, 1'b1);
    drive(1, 1'b1, 8'h02, 1'b0, 1'b1);
    order = 8'h00; cnt0 = 0; cnt1 = 0; ndone = 0;
    for (int n = 0; n < 1200 && ndone < 8; n++) begin
      @(negedge CLK);
      if (sif.DONE0 === 1'b1) begin order = {order[6:0], 1'b0}; cnt0++; ndone++; end
      if (sif.DONE1 === 1'b1) begin order = {order[6:0], 1'b1}; cnt1++; ndone++; end
    end
    sif.REQ0 = 1'b0; sif.REQ1 = 1'b0;
    check("rr_order", order, 8'b0101_0101);
    check("rr_done0_count", cnt0, 4);
    check("rr_done1_count", cnt1, 4);
    repeat (4) @(negedge CLK);

    // Reset after the third SCK rise of an LCD byte
    sdi_pat = 8'h3C;
    drive(0, 1'b1, 8'hA5, 1'b1, 1'b1);
    rises = 0; prev = sif.SCK;
    for (int n = 0; n < 200 && rises < 3; n++) begin
      @(negedge CLK);
      if (sif.SCK === 1'b1 && prev === 1'b0) rises++;
      prev = sif.SCK;
    end
    check("rst_reached_third_rise", rises, 3);
    RST = 1'b1; sif.REQ0 = 1'b0;
    #1;
    check("rst_mid_outputs", {sif.SCK, sif.LCD_CSX, sif.RTP_CSX, sif.BUSY, sif.DONE0, sif.RX0},
          {5'b01100, 8'h00});
    @(negedge CLK); RST = 1'b0;
    seen = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      if (sif.DONE0 === 1'b1) seen++;
    end
    check("rst_no_done", seen, 0);
    xfer(0, 8'hA5, 1'b1, 1'b1, lat, bits, err);
    check("rst_next_latency", lat, 69);
    check("rst_next_sdo_bits", bits, 8'hA5);
    check("rst_next_rx0", sif.RX0, 8'h3C);

    // Minimum divider on the second instance
    sif1.REQ1 = 1'b1; sif1.DATA1 = 8'hFF; sif1.LAST1 = 1'b1;
    d1 = -1; sdo_err = 0; sck_err = 0;
    for (int n = 1; n <= 60 && d1 < 0; n++) begin
      @(negedge CLK);
      if (sif1.SDO !== 1'b1) sdo_err++;
      if (sif1.SCK !== ((n >= 2 && n <= 17 && (n % 2) == 0) ? 1'b1 : 1'b0)) sck_err++;
      if (sif1.DONE1 === 1'b1) d1 = n;
    end
    sif1.REQ1 = 1'b0;
    check("min_done1_cycle", d1, 18);
    check("min_sdo_high", sdo_err, 0);
    check("min_sck_period", sck_err, 0);
    check("min_rx1", sif1.RX1, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_bus_arbiter.md
Name: spi_bus_arbiter

Overview:
- Shares one SPI master shift engine between two requesters: port 0 = LCD controller (ILI9341-style, uses DCX), port 1 = resistive-touch controller (AR1021, RTP_*).
- Sits between the HACK memory-mapped peripheral registers and the board SPI pins.
- Sequences chip-select, DCX, SCK and SDO per byte, and returns the received byte to the owning requester.
- Transactions are multi-byte; bus ownership is locked until the owner's last byte completes.

Parameters:
- CLK_DIV, 4: CLK cycles per SCK half-period; legal range 1..255.
- CS_HOLD, 2: CLK cycles CSX stays deasserted after a transaction before re-arbitration; 1..255.

Ports:
- CLK  in  1  system clock, 100 MHz
- RST  in  1  asynchronous, active-high reset
- REQ0  in  1  LCD byte request; hold high until DONE0
- DATA0  in  8  LCD byte to send; sampled at grant/byte start
- DCX0  in  1  LCD data/command flag for this byte; 1 = data
- LAST0  in  1  byte ends the LCD transaction
- DONE0  out  1  one-cycle pulse when the LCD byte completes
- RX0  out  8  byte shifted in during the last LCD byte; valid from DONE0
- REQ1, DATA1, LAST1, DONE1, RX1: same as above for touch; no DCX
- BUSY  out  1  high whenever state is not IDLE
- SCK  out  1  SPI clock, mode 0; idles low
- SDO  out  1  MOSI, MSB first
- SDI  in  1  MISO, sampled on SCK rising edge
- LCD_CSX  out  1  active-low LCD select
- RTP_CSX  out  1  active-low touch select
- LCD_DCX  out  1  registered DCX0 of the current LCD byte

Behaviour:
- Reset values: SCK=0, SDO=0, LCD_CSX=1, RTP_CSX=1, LCD_DCX=0, DONE0/1=0, RX0/1=0, BUSY=0, owner=0, rr_last=1 (so port 0 wins first).
- States: IDLE, SETUP, SHIFT, DONE, WAIT, HOLD.
- IDLE:
  - If any REQ is high, grant on the next edge.
  - Simultaneous requests: round-robin, the port opposite rr_last wins. Single request: that port wins.
  - On grant: latch owner, DATA, DCX and LAST; assert the owner's CSX low; go to SETUP.
- SETUP: CLK_DIV cycles with SCK=0 and SDO=data[7]; then go to SHIFT.
- SHIFT, bit i from 7 down to 0:
  - SCK high for CLK_DIV cycles; SDI is captured into the shift register on the cycle SCK rises.
  - SCK low for CLK_DIV cycles; SDO is updated to the next bit at the falling edge.
  - After bit 0's high phase, SCK returns low and the state goes to DONE.
- DONE: one cycle.
  - Pulse DONE[owner]; RX[owner] is loaded with the received byte.
  - If the latched LAST=1: deassert CSX, go to HOLD, set rr_last=owner.
  - Otherwise go to WAIT.
- WAIT:
  - CSX stays low; only REQ[owner] is considered; the other port is ignored.
  - REQ[owner] high: latch new DATA, DCX and LAST, go to SETUP.
  - No timeout.
- HOLD: CS_HOLD cycles with both CSX high, then IDLE.
- Byte latency from grant to DONE pulse: 1 + CLK_DIV + 16*CLK_DIV cycles.
- Requester rule: REQ must be dropped in the cycle after DONE, or be high with the next byte. A REQ still high in IDLE/WAIT starts a new byte.
- The non-owner's REQ stays pending; it is granted on the first IDLE after HOLD.
- RX of a port is only updated on that port's DONE. The other port's RX holds its value.
- LCD_DCX updates only for port-0 bytes, at SETUP entry.
- Reset mid-byte: all outputs return to reset values immediately; the partial byte is discarded with no DONE.
- CLK_DIV=1: SCK toggles every cycle (50 MHz); the timing rules above still hold exactly.

Decomposition:
- Shared package spi_pkg: state enum; port-index constants (PORT_LCD=0, PORT_RTP=1); SPI mode constant.
- One sub-module, spi_shift_engine:
  - Contains the divider, bit counter and shift register.
  - Interface: start, tx_byte[7:0] in; sck, sdo, rx_byte[7:0], done out.
  - The arbiter FSM owns grant, lock and the CS/DCX logic.

Test Plan:
- Single LCD byte:
  - Stimulus: REQ0=1, DATA0=8'hA5, DCX0=1, LAST0=1, SDI tied to an 8'h3C pattern, CLK_DIV=4.
  - Response: LCD_CSX low for the full byte; SDO = 1,0,1,0,0,1,0,1 on the rising edges; DONE0 at cycle 69; RX0=8'h3C; LCD_CSX high; BUSY low after 2 HOLD cycles.
- Simultaneous requests after reset:
  - Stimulus: REQ0 and REQ1 rise together, both with LAST=1.
  - Response: port 0 served first. RTP_CSX stays high until LCD_CSX has been high for CS_HOLD cycles; then port 1 is served. DONE1 follows DONE0.
- Locked multi-byte transaction:
  - Stimulus: port 1 sends 5 bytes 8'h80,0A,19,08,16 (LAST only on the 5th), with REQ0 asserted mid-transaction.
  - Response: RTP_CSX stays low across all 5 bytes. LCD_CSX stays high. Port 0 is granted only after HOLD.
- Round-robin fairness:
  - Stimulus: both requesters continuously issue single-byte transactions.
  - Response: grants alternate 0,1,0,1; each DONE count is 4 after 8 transactions.
- Reset mid-transfer:
  - Stimulus: assert RST after 3 SCK rising edges of an LCD byte.
  - Response: SCK=0 and both CSX=1 in the same cycle; no DONE0 pulse; the next byte after reset completes normally.
- Minimum divider:
  - Stimulus: CLK_DIV=1, single RTP byte 8'hFF.
  - Response: SCK period 2 cycles; DONE1 at cycle 18; SDO high throughout the byte.
